// File: rtl/lc3_sequencer_if.sv
// Control bus between the LC-3 sequencer and the datapath stage blocks.
interface lc3_sequencer_if;
  logic [15:0] instr_dout;
  logic        complete_instr;
  logic        complete_data;
  logic [2:0]  psr;
  logic        enable_fetch;
  logic        enable_decode;
  logic        enable_execute;
  logic        enable_writeback;
  logic        enable_updatePC;
  logic        br_taken;
  logic [1:0]  mem_state;
  logic        timeout_err;

  modport master (
    input  instr_dout, complete_instr, complete_data, psr,
    output enable_fetch, enable_decode, enable_execute, enable_writeback,
           enable_updatePC, br_taken, mem_state, timeout_err
  );

  modport slave (
    output instr_dout, complete_instr, complete_data, psr,
    input  enable_fetch, enable_decode, enable_execute, enable_writeback,
           enable_updatePC, br_taken, mem_state, timeout_err
  );
endinterface

// File: rtl/lc3_sequencer.sv
// Multi-cycle LC-3 control FSM: steps each instruction through fetch, decode,
// execute, memory, writeback and PC update, issuing one-hot stage enables.
module lc3_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic            clk,
  input  logic            rst,
  lc3_sequencer_if.master bus
);

  localparam int unsigned IR_W  = 16;
  localparam int unsigned OPC_W = 4;
  localparam int unsigned CNT_W = 16;

  localparam logic [OPC_W-1:0] OP_BR  = 4'b0000;
  localparam logic [OPC_W-1:0] OP_ADD = 4'b0001;
  localparam logic [OPC_W-1:0] OP_LD  = 4'b0010;
  localparam logic [OPC_W-1:0] OP_ST  = 4'b0011;
  localparam logic [OPC_W-1:0] OP_AND = 4'b0101;
  localparam logic [OPC_W-1:0] OP_LDR = 4'b0110;
  localparam logic [OPC_W-1:0] OP_STR = 4'b0111;
  localparam logic [OPC_W-1:0] OP_NOT = 4'b1001;
  localparam logic [OPC_W-1:0] OP_LDI = 4'b1010;
  localparam logic [OPC_W-1:0] OP_STI = 4'b1011;
  localparam logic [OPC_W-1:0] OP_JMP = 4'b1100;
  localparam logic [OPC_W-1:0] OP_LEA = 4'b1110;

  localparam logic [1:0] MS_READ  = 2'd0;
  localparam logic [1:0] MS_WRITE = 2'd1;
  localparam logic [1:0] MS_IND   = 2'd2;
  localparam logic [1:0] MS_IDLE  = 2'd3;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM_IND, S_MEM, S_WRITEBACK, S_UPDATEPC
  } state_e;

  state_e            state_q, state_d;
  logic [IR_W-1:0]   ir_q, ir_d;
  logic              br_q, br_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              terr_q, terr_d;

  logic              en_fetch, en_decode, en_execute, en_writeback, en_updatepc;
  logic              br_out;
  logic [1:0]        mem_st;
  logic [OPC_W-1:0]  opc_c;
  logic              is_store_c;
  logic              timeout_hit_c;
  logic [CNT_W-1:0]  cnt_inc_c;

  assign opc_c         = ir_q[IR_W-1 -: OPC_W];
  assign is_store_c    = (opc_c == OP_ST) || (opc_c == OP_STR) || (opc_c == OP_STI);
  // Counter already holds the waited cycles; this cycle would be the MEM_TIMEOUT-th.
  assign timeout_hit_c = (MEM_TIMEOUT != 0) &&
                         ((32'(cnt_q) + 32'd1) >= 32'(MEM_TIMEOUT));
  assign cnt_inc_c     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    br_d         = br_q;
    cnt_d        = cnt_q;
    terr_d       = terr_q;
    en_fetch     = 1'b0;
    en_decode    = 1'b0;
    en_execute   = 1'b0;
    en_writeback = 1'b0;
    en_updatepc  = 1'b0;
    br_out       = 1'b0;
    mem_st       = MS_IDLE;

    case (state_q)
      S_FETCH: begin
        en_fetch = 1'b1;
        if (bus.complete_instr) begin
          ir_d    = bus.instr_dout;
          state_d = S_DECODE;
        end else begin
          cnt_d = cnt_inc_c;
        end
      end
      S_DECODE: begin
        en_decode = 1'b1;
        state_d   = S_EXECUTE;
      end
      S_EXECUTE: begin
        en_execute = 1'b1;
        br_d       = 1'b0;
        cnt_d      = '0;
        case (opc_c)
          OP_ADD, OP_AND, OP_NOT, OP_LEA: state_d = S_WRITEBACK;
          OP_LD, OP_LDR, OP_ST, OP_STR:   state_d = S_MEM;
          OP_LDI, OP_STI:                 state_d = S_MEM_IND;
          OP_BR: begin
            br_d    = |(ir_q[11:9] & bus.psr);
            state_d = S_UPDATEPC;
          end
          OP_JMP: begin
            br_d    = 1'b1;
            state_d = S_UPDATEPC;
          end
          default: state_d = S_UPDATEPC;
        endcase
      end
      S_MEM_IND: begin
        mem_st = MS_IND;
        if (bus.complete_data) begin
          cnt_d   = '0;
          state_d = S_MEM;
        end else if (timeout_hit_c) begin
          terr_d  = 1'b1;
          br_d    = 1'b0;
          state_d = S_UPDATEPC;
        end else begin
          cnt_d = cnt_inc_c;
        end
      end
      S_MEM: begin
        mem_st = is_store_c ? MS_WRITE : MS_READ;
        if (bus.complete_data) begin
          state_d = is_store_c ? S_UPDATEPC : S_WRITEBACK;
        end else if (timeout_hit_c) begin
          terr_d  = 1'b1;
          br_d    = 1'b0;
          state_d = S_UPDATEPC;
        end else begin
          cnt_d = cnt_inc_c;
        end
      end
      S_WRITEBACK: begin
        en_writeback = 1'b1;
        state_d      = S_UPDATEPC;
      end
      S_UPDATEPC: begin
        en_updatepc = 1'b1;
        br_out      = br_q;
        cnt_d       = '0;
        state_d     = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset quiets the stage enables immediately, even before the state register resets.
  assign bus.enable_fetch     = en_fetch & ~rst;
  assign bus.enable_decode    = en_decode & ~rst;
  assign bus.enable_execute   = en_execute & ~rst;
  assign bus.enable_writeback = en_writeback & ~rst;
  assign bus.enable_updatePC  = en_updatepc & ~rst;
  assign bus.br_taken         = br_out & ~rst;
  assign bus.mem_state        = rst ? MS_IDLE : mem_st;
  assign bus.timeout_err      = terr_q;

endmodule

// File: tb/tb_lc3_sequencer.sv
// Randomized scoreboard bench for lc3_sequencer: an instruction-level model
// queues the expected per-cycle outputs and a monitor compares them.
module tb_lc3_sequencer;

  localparam int unsigned TMO = 4;

  localparam logic [4:0] EN_NONE = 5'b00000;
  localparam logic [4:0] EN_F    = 5'b10000;
  localparam logic [4:0] EN_D    = 5'b01000;
  localparam logic [4:0] EN_E    = 5'b00100;
  localparam logic [4:0] EN_W    = 5'b00010;
  localparam logic [4:0] EN_U    = 5'b00001;

  typedef struct {
    logic [8:0] v;
    string      tag;
  } exp_t;

  logic clk;
  logic rst;
  lc3_sequencer_if bus ();

  lc3_sequencer #(.MEM_TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_err  = 0;
  logic terr_m = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expected vector per driven cycle, compared mid-cycle.
  exp_t       mon_e;
  logic [8:0] mon_act;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      mon_act = {bus.enable_fetch, bus.enable_decode, bus.enable_execute,
                 bus.enable_writeback, bus.enable_updatePC, bus.br_taken,
                 bus.mem_state, bus.timeout_err};
      n_vec++;
      if (mon_act !== mon_e.v) begin
        n_err++;
        $display("FAIL %s at %0t: got {en,br,ms,terr}=%b required %b",
                 mon_e.tag, $time, mon_act, mon_e.v);
      end
    end
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock cycle: apply inputs just after the edge and queue the expected outputs.
  task automatic cyc(input logic r, input logic ci, input logic cd,
                     input logic [15:0] ins, input logic [2:0] p,
                     input logic [4:0] en, input logic br, input logic [1:0] ms,
                     input bit chk, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst                = r;
    bus.complete_instr = ci;
    bus.complete_data  = cd;
    bus.instr_dout     = ins;
    bus.psr            = p;
    if (chk) begin
      e.v   = {en, br, ms, terr_m};
      e.tag = tag;
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, rb(), rb(), 16'($urandom), 3'($urandom), EN_NONE, 1'b0, 2'd3, 1'b1, "reset");
      terr_m = 1'b0;
    end
  endtask

  // Memory wait of w cycles before the handshake; w >= TMO means it never arrives.
  task automatic data_phase(input logic [1:0] ms, input int w, output bit ok);
    int n;
    n = (w >= int'(TMO)) ? int'(TMO) : w + 1;
    for (int i = 0; i < n; i++)
      cyc(1'b0, rb(), (w < int'(TMO)) && (i == w), 16'($urandom), 3'($urandom),
          EN_NONE, 1'b0, ms, 1'b1, "mem_wait");
    ok = (w < int'(TMO));
    if (!ok) terr_m = 1'b1;
  endtask

  // Whole instruction, expectations derived from the ISA-level cycle plan.
  task automatic run_instr(input logic [15:0] ins, input int fw, input int w1,
                           input int w2, input int psr_force);
    logic [3:0] op;
    logic [2:0] p;
    logic       br;
    bit         ok;
    op = ins[15:12];
    for (int i = 0; i < fw; i++)
      cyc(1'b0, 1'b0, rb(), 16'($urandom), 3'($urandom), EN_F, 1'b0, 2'd3, 1'b1, "fetch_wait");
    cyc(1'b0, 1'b1, rb(), ins, 3'($urandom), EN_F, 1'b0, 2'd3, 1'b1, "fetch");
    cyc(1'b0, rb(), rb(), 16'($urandom), 3'($urandom), EN_D, 1'b0, 2'd3, 1'b1, "decode");
    p = (psr_force >= 0) ? 3'(psr_force) : 3'($urandom);
    cyc(1'b0, rb(), rb(), 16'($urandom), p, EN_E, 1'b0, 2'd3, 1'b1, "execute");
    br = 1'b0;
    ok = 1'b1;
    case (op)
      4'b0001, 4'b0101, 4'b1001, 4'b1110:
        cyc(1'b0, rb(), rb(), 16'($urandom), 3'($urandom), EN_W, 1'b0, 2'd3, 1'b1, "writeback");
      4'b0010, 4'b0110: begin
        data_phase(2'd0, w1, ok);
        if (ok)
          cyc(1'b0, rb(), rb(), 16'($urandom), 3'($urandom), EN_W, 1'b0, 2'd3, 1'b1, "writeback");
      end
      4'b0011, 4'b0111: data_phase(2'd1, w1, ok);
      4'b1010, 4'b1011: begin
        data_phase(2'd2, w1, ok);
        if (ok) data_phase((op == 4'b1010) ? 2'd0 : 2'd1, w2, ok);
        if (ok && op == 4'b1010)
          cyc(1'b0, rb(), rb(), 16'($urandom), 3'($urandom), EN_W, 1'b0, 2'd3, 1'b1, "writeback");
      end
      4'b0000: br = (ins[11:9] & p) != 3'b000;
      4'b1100: br = 1'b1;
      default: br = 1'b0;
    endcase
    cyc(1'b0, rb(), rb(), 16'($urandom), 3'($urandom), EN_U, br, 2'd3, 1'b1, "updatepc");
  endtask

  initial begin
    rst                = 1'b1;
    bus.complete_instr = 1'b0;
    bus.complete_data  = 1'b0;
    bus.instr_dout     = '0;
    bus.psr            = '0;
    cyc(1'b1, 1'b0, 1'b0, 16'h0000, 3'b000, EN_NONE, 1'b0, 2'd3, 1'b0, "reset");
    do_reset(2);

    run_instr(16'h1042, 0, 0, 0, -1);
    run_instr(16'hA402, 0, 2, 0, -1);
    run_instr(16'h7281, 1, 3, 0, -1);
    run_instr(16'h0405, 0, 0, 0, 3'b010);
    run_instr(16'h0405, 2, 0, 0, 3'b001);
    run_instr(16'hC1C0, 0, 0, 0, -1);
    run_instr(16'hF025, 0, 0, 0, -1);
    run_instr(16'h2201, 0, 10, 0, -1);
    run_instr(16'h1042, 0, 0, 0, -1);
    do_reset(1);
    run_instr(16'hB601, 0, 1, 7, -1);
    do_reset(1);

    // Reset arriving while an LD waits in MEM abandons it without writeback.
    cyc(1'b0, 1'b1, 1'b0, 16'h2201, 3'b000, EN_F, 1'b0, 2'd3, 1'b1, "rst_ld_fetch");
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 3'b000, EN_D, 1'b0, 2'd3, 1'b1, "rst_ld_decode");
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 3'b000, EN_E, 1'b0, 2'd3, 1'b1, "rst_ld_execute");
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 3'b000, EN_NONE, 1'b0, 2'd0, 1'b1, "rst_ld_mem");
    cyc(1'b1, 1'b0, 1'b1, 16'h0000, 3'b000, EN_NONE, 1'b0, 2'd3, 1'b1, "rst_mid_mem");
    cyc(1'b1, 1'b1, 1'b1, 16'h0000, 3'b000, EN_NONE, 1'b0, 2'd3, 1'b1, "rst_hold");
    cyc(1'b0, 1'b0, 1'b1, 16'h0000, 3'b000, EN_F, 1'b0, 2'd3, 1'b1, "rst_release_fetch");
    run_instr(16'h5042, 0, 0, 0, -1);

    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 19) == 0) do_reset($urandom_range(1, 2));
      run_instr(16'($urandom), $urandom_range(0, 3), $urandom_range(0, 5),
                $urandom_range(0, 5), -1);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending vectors required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
